// File: rtl/pe_retrans_req_gen_pkg.sv
// Shared definitions for the retransmission-request generator: packet field
// bounds, field widths, packet type codes and the generator FSM encoding.
package pe_retrans_req_gen_pkg;

  localparam int ID_W   = 4;
  localparam int TIME_W = 10;
  localparam int DATA_W = 20;
  localparam int TYPE_W = 2;
  localparam int PKT_W  = 40;
  localparam int GAP_W  = 3;

  localparam int SRC_MAX  = 39;
  localparam int SRC_MIN  = 36;
  localparam int DST_MAX  = 35;
  localparam int DST_MIN  = 32;
  localparam int TIME_MAX = 31;
  localparam int TIME_MIN = 22;
  localparam int DATA_MAX = 21;
  localparam int DATA_MIN = 2;
  localparam int TYPE_MAX = 1;
  localparam int TYPE_MIN = 0;

  localparam logic [TYPE_W-1:0] TYPE_NORMAL  = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_REQUEST = 2'b10;
  localparam logic [TYPE_W-1:0] TYPE_RETRANS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10
  } req_state_e;

  // Assemble a router packet from its individual fields.
  function automatic logic [PKT_W-1:0] pack_pkt(
    input logic [ID_W-1:0]   src,
    input logic [ID_W-1:0]   dst,
    input logic [TIME_W-1:0] ts,
    input logic [DATA_W-1:0] data,
    input logic [TYPE_W-1:0] typ
  );
    logic [PKT_W-1:0] p;
    p = {PKT_W{1'b0}};
    p[SRC_MAX:SRC_MIN]   = src;
    p[DST_MAX:DST_MIN]   = dst;
    p[TIME_MAX:TIME_MIN] = ts;
    p[DATA_MAX:DATA_MIN] = data;
    p[TYPE_MAX:TYPE_MIN] = typ;
    return p;
  endfunction

endpackage

// File: rtl/pe_retrans_req_gen_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after the pointer wins.
// The pointer moves past the served slot only when the packet is accepted,
// so a held packet never lets another requester overtake it.
module pe_retrans_req_gen_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  input  logic [IW-1:0] accept_idx,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  logic [IW-1:0] ptr_r;

  // Search the requests starting at the pointer, wrapping once around.
  always_comb begin
    int j;
    j         = 0;
    gnt_oh    = {N{1'b0}};
    gnt_idx   = {IW{1'b0}};
    gnt_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_r) + k) % N;
      if (!gnt_valid && req[j]) begin
        gnt_oh[j] = 1'b1;
        gnt_idx   = IW'(j);
        gnt_valid = 1'b1;
      end else begin
        // an earlier slot in search order already won
        gnt_valid = gnt_valid;
      end
    end
  end

  // Advance the pointer to the slot after the one just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IW{1'b0}};
    end else if (accept) begin
      ptr_r <= (accept_idx == IW'(N - 1)) ? {IW{1'b0}} : accept_idx + IW'(1);
    end
  end

endmodule

// File: rtl/pe_retrans_req_gen.sv
// Retransmission-request generator. Arbitrates the miss indications of the
// per-target trackers and offers one REQUEST packet per grant to the router.
// The DATA field follows the granted tracker's diff counter live while the
// packet is held, so counts that grow during backpressure are not lost.
module pe_retrans_req_gen
  import pe_retrans_req_gen_pkg::*;
#(
  parameter logic [ID_W-1:0]   MY_ID    = 4'b0000,
  parameter int                NUM_TGT  = 8,
  parameter logic [TYPE_W-1:0] REQ_TYPE = TYPE_REQUEST,
  parameter int                MIN_GAP  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_TGT-1:0]        miss_vec,
  input  logic [NUM_TGT*DATA_W-1:0] diff_vec,
  input  logic [NUM_TGT*ID_W-1:0]   tgt_id_vec,
  output logic [PKT_W-1:0]          pkt_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic                      request_out_flag,
  output logic [ID_W-1:0]           request_dst,
  output logic                      hold_out_flag,
  output logic [15:0]               req_sent_cnt
);

  localparam int IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : GAP_W'(0);

  req_state_e          state_r;
  req_state_e          state_nx;
  logic [IW-1:0]       grant_r;
  logic [ID_W-1:0]     dst_r;
  logic [TIME_W-1:0]   ts_r;
  logic [15:0]         cnt_r;
  logic [GAP_W-1:0]    gap_r;
  logic                valid_r;

  logic [NUM_TGT-1:0]  gnt_oh_s;
  logic [IW-1:0]       gnt_idx_s;
  logic                gnt_any_s;
  logic                load_s;
  logic                accept_s;
  logic [ID_W-1:0]     dst_sel_s;
  logic [DATA_W-1:0]   data_live_s;

  pe_retrans_req_gen_rr_arbiter #(
    .N  (NUM_TGT),
    .IW (IW)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (miss_vec),
    .accept     (accept_s),
    .accept_idx (grant_r),
    .gnt_oh     (gnt_oh_s),
    .gnt_idx    (gnt_idx_s),
    .gnt_valid  (gnt_any_s)
  );

  // Next-state decode and the load/accept strobes for the datapath.
  always_comb begin
    state_nx = state_r;
    load_s   = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && gnt_any_s) begin
          state_nx = ST_SEND;
          load_s   = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (pkt_ready) begin
          accept_s = 1'b1;
          state_nx = (MIN_GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          state_nx = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_W'(0)) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_GAP;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // One-hot AND-OR mux of the winner's target ID, locked at grant time.
  always_comb begin
    dst_sel_s = {ID_W{1'b0}};
    for (int i = 0; i < NUM_TGT; i++) begin
      dst_sel_s = dst_sel_s | (tgt_id_vec[ID_W*i +: ID_W] & {ID_W{gnt_oh_s[i]}});
    end
  end

  // Live diff counter of the locked grant, re-sampled every cycle.
  always_comb begin
    data_live_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_TGT; i++) begin
      if (grant_r == IW'(i)) begin
        data_live_s = diff_vec[DATA_W*i +: DATA_W];
      end else begin
        data_live_s = data_live_s;
      end
    end
  end

  // Packet registers: lock grant on entry to SEND, bump TIME/count on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      grant_r <= {IW{1'b0}};
      dst_r   <= {ID_W{1'b0}};
      ts_r    <= {TIME_W{1'b0}};
      cnt_r   <= 16'h0000;
    end else if (load_s) begin
      valid_r <= 1'b1;
      grant_r <= gnt_idx_s;
      dst_r   <= dst_sel_s;
    end else if (accept_s) begin
      valid_r <= 1'b0;
      dst_r   <= {ID_W{1'b0}};
      ts_r    <= ts_r + 10'd1;
      if (cnt_r != 16'hFFFF) begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  // Post-accept idle counter; loaded on accept, counts down while in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= GAP_W'(0);
    end else if (accept_s) begin
      gap_r <= GAP_LOAD;
    end else if ((state_r == ST_GAP) && (gap_r != GAP_W'(0))) begin
      gap_r <= gap_r - 3'd1;
    end
  end

  assign pkt_data         = valid_r ? pack_pkt(MY_ID, dst_r, ts_r, data_live_s, REQ_TYPE)
                                    : {PKT_W{1'b0}};
  assign pkt_valid        = valid_r;
  assign request_out_flag = valid_r;
  assign hold_out_flag    = valid_r & ~pkt_ready;
  assign request_dst      = dst_r;
  assign req_sent_cnt     = cnt_r;

endmodule
